// File: rtl/cla_multicycle_add_seq_pkg.sv
// -----------------------------------------------------------------------------
// cla_multicycle_add_seq_pkg
//   Shared definitions for the nibble-serial carry-lookahead add/subtract
//   sequencer: FSM state encoding, the adder cell width and a small helper
//   for two's-complement overflow detection.
// -----------------------------------------------------------------------------
package cla_multicycle_add_seq_pkg;

  // Width of the single carry-lookahead cell that is reused on every pass.
  localparam int NIBBLE_W = 4;

  // Sequencer states. The encoding is fixed so it can be probed directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of r = a + b' : both addends share a sign bit and the
  // result sign differs from it. For subtraction b' is the inverted B operand.
  function automatic logic add_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_multicycle_add_seq_if.sv
// -----------------------------------------------------------------------------
// cla_multicycle_add_seq_if
//   Operand/result handshake bundle for cla_multicycle_add_seq.
//   Input side : in_valid/in_ready with op_sub, a, b.
//   Output side: out_valid/out_ready with result, cout, ovf, zero.
//   master - the ALU op decoder / result consumer that drives the block.
//   slave  - the add/subtract sequencer itself.
// -----------------------------------------------------------------------------
interface cla_multicycle_add_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid,
    output op_sub,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  cout,
    input  ovf,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  op_sub,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output cout,
    output ovf,
    output zero
  );

endinterface

// File: rtl/cla_nibble_stage.sv
// -----------------------------------------------------------------------------
// cla_nibble_stage
//   4-bit carry-lookahead adder cell plus the carry register that chains one
//   pass to the next.
//   Ports:
//     clk, rst_n  clock and synchronous active-low reset
//     a, b        nibble operands for the current pass
//     load, init  load the carry register with init (start of an operation)
//     en          capture the cell carry-out into the carry register
//     sum         combinational nibble sum (uses the registered carry as cin)
//     cout        combinational carry out of the nibble (c4)
// -----------------------------------------------------------------------------
module cla_nibble_stage
  import cla_multicycle_add_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                load,
  input  logic                init,
  input  logic                en,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic                carry_q;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Flat lookahead: every carry is a two-level function of p, g and cin,
  // so no carry ripples through the cell.
  assign c[0] = carry_q;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[NIBBLE_W-1:0];
  assign cout = c[4];

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= init;
    end else if (en) begin
      carry_q <= c[4];
    end
  end

endmodule

// File: rtl/cla_multicycle_add_seq.sv
// -----------------------------------------------------------------------------
// cla_multicycle_add_seq
//   WIDTH-bit add/subtract built from one 4-bit carry-lookahead cell that is
//   sequenced over WIDTH/4 cycles, least-significant nibble first. Subtraction
//   is a + ~b + 1: B is inverted when latched and the carry starts at 1.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset; discards any operation in flight
//     bus    slave side of cla_multicycle_add_seq_if
//            in_valid/in_ready/op_sub/a/b      operand handshake
//            out_valid/out_ready/result/cout/ovf/zero  result handshake
//   Flags: cout is the carry out of the MSB (for subtract, 1 = no borrow),
//   ovf is two's-complement overflow, zero flags an all-zero result.
// -----------------------------------------------------------------------------
module cla_multicycle_add_seq
  import cla_multicycle_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_multicycle_add_seq_if.slave bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB   = WIDTH - 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;       // B already inverted for subtraction
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_next;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               cout_q;
  logic               ovf_q;
  logic               zero_q;

  logic               accept;
  logic               last;
  logic [NIBBLE_W-1:0] nib_sum;
  logic               nib_cout;

  // in_ready_q is high exactly when the FSM is in IDLE.
  assign accept = bus.in_valid && in_ready_q;
  // Terminal pass is detected by compare, so idx never needs to wrap.
  assign last   = (idx == IDX_W'(NIB - 1));

  cla_nibble_stage u_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_q[NIBBLE_W*idx +: NIBBLE_W]),
    .b     (b_q[NIBBLE_W*idx +: NIBBLE_W]),
    .load  (accept),
    .init  (bus.op_sub),
    .en    (state == RUN),
    .sum   (nib_sum),
    .cout  (nib_cout)
  );

  // Result with the current pass merged in; used both for the register update
  // and for deriving the flags on the final pass in the same edge.
  // NOTE: the full default assignment before the partial overwrite keeps this
  // block purely combinational (no latch on the untouched bits).
  always_comb begin
    result_next = result_q;
    result_next[NIBBLE_W*idx +: NIBBLE_W] = nib_sum;
  end

  // NOTE: operand registers are pure datapath qualified by the FSM, so they
  // carry no reset; only control and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b ^ {WIDTH{bus.op_sub}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RUN;
            idx        <= '0;
            result_q   <= '0;
            in_ready_q <= 1'b0;
          end
        end

        RUN: begin
          result_q <= result_next;
          if (last) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= nib_cout;
            ovf_q       <= add_ovf(a_q[MSB], b_q[MSB], result_next[MSB]);
            zero_q      <= (result_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          // Re-accept is deliberately deferred: in_ready only rises next cycle.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_multicycle_add_seq.sv
// -----------------------------------------------------------------------------
// tb_cla_multicycle_add_seq
//   Directed checks on a WIDTH=16 instance (flags, latency, backpressure,
//   mid-operation reset) and a WIDTH=4 instance (directed plus random ops
//   against an arithmetic reference).
// -----------------------------------------------------------------------------
module tb_cla_multicycle_add_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cla_multicycle_add_seq_if #(.WIDTH(16)) bus16 ();
  cla_multicycle_add_seq_if #(.WIDTH(4))  bus4 ();

  cla_multicycle_add_seq #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  cla_multicycle_add_seq #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every drive and sample happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic sub, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ec, input logic eo, input logic ez);
    int cyc;
    bus16.op_sub   = sub;
    bus16.a        = a;
    bus16.b        = b;
    bus16.in_valid = 1'b1;
    check("w16_in_ready_idle", bus16.in_ready, 1);
    tick();
    bus16.in_valid = 1'b0;
    check("w16_in_ready_busy", bus16.in_ready, 0);
    cyc = 0;
    while (!bus16.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("w16_latency", cyc, 4);
    check("w16_result", bus16.result, er);
    check("w16_cout", bus16.cout, ec);
    check("w16_ovf", bus16.ovf, eo);
    check("w16_zero", bus16.zero, ez);
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check("w16_out_valid_drop", bus16.out_valid, 0);
    check("w16_in_ready_back", bus16.in_ready, 1);
  endtask

  task automatic run4(input logic sub, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] er, input logic ec, input logic eo, input logic ez);
    int cyc;
    bus4.op_sub   = sub;
    bus4.a        = a;
    bus4.b        = b;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    cyc = 0;
    while (!bus4.out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("w4_latency", cyc, 1);
    check("w4_result", bus4.result, er);
    check("w4_cout", bus4.cout, ec);
    check("w4_ovf", bus4.ovf, eo);
    check("w4_zero", bus4.zero, ez);
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check("w4_out_valid_drop", bus4.out_valid, 0);
  endtask

  initial begin
    int cyc;
    bus16.in_valid = 1'b0; bus16.op_sub = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.op_sub  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.out_ready  = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", bus16.in_ready, 1);
    check("rst_out_valid", bus16.out_valid, 0);
    check("rst_result", bus16.result, 16'h0000);
    check("rst_flags", {bus16.cout, bus16.ovf, bus16.zero}, 3'b000);
    check("rst_w4_in_ready", bus4.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Directed WIDTH=16 vectors: sub, a, b, result, cout, ovf, zero
    run16(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    run16(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    run16(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    run16(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run16(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run16(1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: result held for 10 cycles, a stray in_valid is ignored
    bus16.op_sub = 1'b0; bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    cyc = 0;
    while (!bus16.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bp_latency", cyc, 4);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus16.a = 16'hAAAA; bus16.b = 16'h1111; bus16.in_valid = 1'b1;
      end else begin
        bus16.in_valid = 1'b0;
      end
      tick();
      check("bp_out_valid", bus16.out_valid, 1);
      check("bp_result", bus16.result, 16'h5555);
      check("bp_flags", {bus16.cout, bus16.ovf, bus16.zero}, 3'b000);
      check("bp_in_ready", bus16.in_ready, 0);
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check("bp_release_out_valid", bus16.out_valid, 0);
    check("bp_release_in_ready", bus16.in_ready, 1);
    check("bp_idle_result_kept", bus16.result, 16'h5555);

    // Reset during the second RUN cycle discards the operation
    bus16.op_sub = 1'b0; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", bus16.in_ready, 1);
    check("midrst_out_valid", bus16.out_valid, 0);
    check("midrst_result", bus16.result, 16'h0000);
    check("midrst_flags", {bus16.cout, bus16.ovf, bus16.zero}, 3'b000);
    run16(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

    // WIDTH=4 directed
    run4(1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
    run4(1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
    run4(1'b1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0);

    // WIDTH=4 random against integer arithmetic
    for (int n = 0; n < 10000; n++) begin
      logic       sub;
      logic [3:0] ra, rb, er;
      logic       ec, eo;
      int         sa, sb, sr;
      sub = 1'($urandom_range(1));
      ra  = 4'($urandom_range(15));
      rb  = 4'($urandom_range(15));
      sa  = (ra >= 8) ? int'(ra) - 16 : int'(ra);
      sb  = (rb >= 8) ? int'(rb) - 16 : int'(rb);
      if (sub) begin
        er = 4'((int'(ra) - int'(rb)) & 15);
        ec = (ra >= rb);
        sr = sa - sb;
      end else begin
        er = 4'((int'(ra) + int'(rb)) & 15);
        ec = ((int'(ra) + int'(rb)) > 15);
        sr = sa + sb;
      end
      eo = (sr > 7) || (sr < -8);
      run4(sub, ra, rb, er, ec, eo, (er == 4'h0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
